// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// LOGIC_UNIT_PIPE_PARITY_EN adds the par result bit.
interface logic_unit_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] c;
   logic             zero;
   logic             out_valid;
   logic             out_ready;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   logic             par;

   modport master (
      output a, b, op, in_valid, out_ready,
      input  in_ready, c, zero, out_valid, par
   );
   modport slave (
      input  a, b, op, in_valid, out_ready,
      output in_ready, c, zero, out_valid, par
   );
`else
   modport master (
      output a, b, op, in_valid, out_ready,
      input  in_ready, c, zero, out_valid
   );
   modport slave (
      input  a, b, op, in_valid, out_ready,
      output in_ready, c, zero, out_valid
   );
`endif
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined 8-function bitwise logic unit with valid/ready flow control.
// LOGIC_UNIT_PIPE_PARITY_EN adds an even-parity bit carried with each result.
module logic_unit_pipe #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   logic_unit_pipe_if.slave bus,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_ANDN = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   logic [STAGES-1:0] r_v;
   logic [WIDTH-1:0]  r_d [STAGES];
   logic [STAGES-1:0] r_z;
   logic [CNT_W-1:0]  r_cnt;
   logic [STAGES-1:0] w_load;
   logic [WIDTH-1:0]  w_res;
   logic              w_zero;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   logic [STAGES-1:0] r_p;
`endif

   always_comb begin
      w_res = '0;
      case (op_e'(bus.op))
         OP_AND:  w_res = bus.a & bus.b;
         OP_OR:   w_res = bus.a | bus.b;
         OP_XOR:  w_res = bus.a ^ bus.b;
         OP_NAND: w_res = ~(bus.a & bus.b);
         OP_NOR:  w_res = ~(bus.a | bus.b);
         OP_XNOR: w_res = ~(bus.a ^ bus.b);
         OP_ANDN: w_res = bus.a & ~bus.b;
         OP_PASS: w_res = bus.a;
         default: w_res = '0;
      endcase
      w_zero = (w_res == '0);
   end

   // Stage k may load when the consumer is taking data or any stage from k
   // onward is empty; this is the unrolled ready chain, so no bubbles form.
   always_comb begin
      w_load = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         w_load[k] = bus.out_ready;
         for (int unsigned j = k; j < STAGES; j++) begin
            if (!r_v[j]) w_load[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v   <= '0;
         r_z   <= '0;
         r_cnt <= '0;
         for (int unsigned k = 0; k < STAGES; k++) r_d[k] <= '0;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
         r_p   <= '0;
`endif
      end else begin
         if (w_load[0]) begin
            r_v[0] <= bus.in_valid;
            if (bus.in_valid) begin
               r_d[0] <= w_res;
               r_z[0] <= w_zero;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
               r_p[0] <= ^w_res;
`endif
            end
         end
         for (int unsigned k = 1; k < STAGES; k++) begin
            if (w_load[k]) begin
               r_v[k] <= r_v[k-1];
               if (r_v[k-1]) begin
                  r_d[k] <= r_d[k-1];
                  r_z[k] <= r_z[k-1];
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
                  r_p[k] <= r_p[k-1];
`endif
               end
            end
         end
         if (r_v[STAGES-1] && bus.out_ready) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.in_ready  = w_load[0];
   assign bus.c         = r_d[STAGES-1];
   assign bus.zero      = r_z[STAGES-1];
   assign bus.out_valid = r_v[STAGES-1];
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
   assign bus.par       = r_p[STAGES-1];
`endif
   assign busy          = |r_v;
   assign done_cnt      = r_cnt;

endmodule
